regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised integer register file for the pipelined core: NUM_RD combinational read ports,
//  one synchronous write port, write-to-read bypass and a per-register busy scoreboard.
//  Busy bits are set at issue (decode) for a pending destination and cleared at writeback.
//  Hazard logic in decode uses them to stall. Register 0 is hardwired to zero and never busy.
// PARAMETERS
//  XLEN      32  data width of each register
//  NUM_REGS  32  number of architectural registers (power of two, >=2)
//  NUM_RD    2   number of independent read ports (1..4)
//  AW        $clog2(NUM_REGS)  address width (derived localparam, not overridable)
// PORTS
//  i_Clk        in   1            clock; all state updates on rising edge
//  i_Reset      in   1            asynchronous, active-low reset
//  i_rAddr      in   NUM_RD x AW  read address per port
//  o_rData      out  NUM_RD x XLEN read data per port (combinational)
//  o_rBusy      out  NUM_RD       read register has a pending write not yet available
//  i_wEnable    in   1            writeback valid
//  i_wAddr      in   AW           writeback destination
//  i_wData      in   XLEN         writeback data
//  i_IssueValid in   1            instruction with a destination issues this cycle
//  i_IssueAddr  in   AW           destination register of issuing instruction
//  i_Flush      in   1            pipeline flush: discard all pending busy bits
//  o_BusyCount  out  AW+1         number of registers currently marked busy
// BEHAVIOUR
//  Reset (i_Reset=0, async): all registers = 0, all busy bits = 0, o_BusyCount = 0.
//   Outputs during reset: o_rData = 0, o_rBusy = 0 for every port.
//  Write: on posedge, if i_wEnable && i_wAddr!=0, mem[i_wAddr] <= i_wData. Writes to 0 dropped.
//  Read, per port p, priority order:
//   1. i_rAddr[p]==0                                 -> o_rData=0, o_rBusy=0
//   2. i_wEnable && i_wAddr==i_rAddr[p]              -> o_rData=i_wData (bypass), o_rBusy=0
//   3. otherwise                                     -> o_rData=mem[addr], o_rBusy=busy[addr]
//   Bypass means same-cycle writeback is visible to a reader with zero latency.
//  Scoreboard, per register r!=0, next state evaluated on posedge:
//   i_Flush=1                                        -> busy[r] <= 0 (overrides all below)
//   i_IssueValid && i_IssueAddr==r                   -> busy[r] <= 1 (set wins over clear:
//                                                       a new producer replaces the old one)
//   else i_wEnable && i_wAddr==r                     -> busy[r] <= 0
//   else hold. busy[0] is constant 0; issue/writeback to 0 have no scoreboard effect.
//  Writeback to a non-busy register is legal: data written, busy stays 0.
//  Flush does not block the same-cycle write; the data write still occurs.
//  o_BusyCount: registered popcount of busy[], updated same edge as busy[]; never
//   exceeds NUM_REGS-1. Counter is exact at all times, including under set+clear collisions.
//  Reset asserted mid-operation clears state immediately; first post-reset edge behaves
//   as if from cold.
//  No X propagation: out-of-range addresses impossible (NUM_REGS is a power of two).
// STRUCTURE
//  Package regfile_pkg: default XLEN/NUM_REGS constants, typedef reg_addr_t (logic[AW-1:0]),
//   typedef xlen_t (logic[XLEN-1:0]), shared with decode hazard unit and writeback stage.
//  Sub-module regfile_busy_table: busy bit vector, set/clear/flush priority, popcount
//   register. Top holds storage array, write logic and per-port read/bypass muxes (generate loop).
// TESTING
//  1 Reset: write 0xDEADBEEF to r5, assert i_Reset low mid-cycle -> r5 reads 0, o_BusyCount=0
//    immediately, before next edge.
//  2 Zero reg: write 0x1234 to r0, issue to r0 -> reading r0 gives 0, o_rBusy=0, count unchanged.
//  3 Bypass: same cycle i_wEnable, wAddr=7, wData=0xA5A5A5A5, rAddr[0]=rAddr[1]=7 -> both ports
//    read 0xA5A5A5A5 with rBusy=0; next cycle mem read gives same value.
//  4 Scoreboard: issue r3 -> next cycle rBusy=1, count=1; writeback r3=0x55 -> same-cycle read
//    0x55/rBusy=0, next cycle count=0.
//  5 Collision: issue r9 and writeback r9 same edge -> busy[9]=1 after edge, count unchanged if r9 already busy.
//  6 Flush: issue r1,r2,r4 on successive cycles (count=3), assert i_Flush -> count=0,
//    all rBusy=0; a concurrent writeback to r2 still updates its data.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and types used by decode hazard logic,
// writeback and the register file itself.
package regfile_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int NUM_RD_DEF   = 2;
    localparam int AW_DEF       = $clog2(NUM_REGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/regfile_busy_table.sv
// Per-register pending-write scoreboard: flush > issue-set > writeback-clear,
// plus a registered popcount of the busy vector.
module regfile_busy_table
    import regfile_pkg::*;
#(
    parameter int  NUM_REGS = NUM_REGS_DEF,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    input  logic                i_IssueValid,
    input  logic [AW-1:0]       i_IssueAddr,
    input  logic                i_wEnable,
    input  logic [AW-1:0]       i_wAddr,
    input  logic                i_Flush,
    output logic [NUM_REGS-1:0] o_busy,
    output logic [AW:0]         o_BusyCount
);

    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;
    logic [AW:0]         count_reg;
    logic [AW:0]         count_next;

    assign busy_next[0] = 1'b0;

    // A new producer replaces the old one, so set beats a same-cycle clear.
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
        assign busy_next[gi] = i_Flush                                    ? 1'b0 :
                               (i_IssueValid && i_IssueAddr == AW'(gi))   ? 1'b1 :
                               (i_wEnable && i_wAddr == AW'(gi))          ? 1'b0 :
                                                                            busy_reg[gi];
    end

    // Counting the next vector keeps the count exact under any set/clear mix.
    always_comb begin
        count_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            count_next = count_next + (AW+1)'(busy_next[i]);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            busy_reg  <= '0;
            count_reg <= '0;
        end else begin
            busy_reg  <= busy_next;
            count_reg <= count_next;
        end
    end

    assign o_busy      = busy_reg;
    assign o_BusyCount = count_reg;

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file: NUM_RD combinational read ports with writeback bypass,
// one synchronous write port, r0 hardwired to zero, and a busy scoreboard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  XLEN     = XLEN_DEF,
    parameter int  NUM_REGS = NUM_REGS_DEF,
    parameter int  NUM_RD   = NUM_RD_DEF,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic [NUM_RD*AW-1:0]   i_rAddr,
    output logic [NUM_RD*XLEN-1:0] o_rData,
    output logic [NUM_RD-1:0]      o_rBusy,
    input  logic                   i_wEnable,
    input  logic [AW-1:0]          i_wAddr,
    input  logic [XLEN-1:0]        i_wData,
    input  logic                   i_IssueValid,
    input  logic [AW-1:0]          i_IssueAddr,
    input  logic                   i_Flush,
    output logic [AW:0]            o_BusyCount
);

    logic [XLEN-1:0]     mem_reg [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    // Entry 0 is cleared by reset and never written, so it stays zero.
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (i_wEnable && i_wAddr != '0) begin
            mem_reg[i_wAddr] <= i_wData;
        end
    end

    regfile_busy_table #(
        .NUM_REGS (NUM_REGS)
    ) u_busy_table (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .i_IssueValid (i_IssueValid),
        .i_IssueAddr  (i_IssueAddr),
        .i_wEnable    (i_wEnable),
        .i_wAddr      (i_wAddr),
        .i_Flush      (i_Flush),
        .o_busy       (busy),
        .o_BusyCount  (o_BusyCount)
    );

    // Outputs are forced quiet while reset is held, even with a live writeback.
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [AW-1:0]   rd_addr;
        logic [XLEN-1:0] rd_data;
        logic            rd_busy;

        assign rd_addr = i_rAddr[gi*AW +: AW];

        always_comb begin
            rd_data = '0;
            rd_busy = 1'b0;
            if (i_Reset && rd_addr != '0) begin
                if (i_wEnable && i_wAddr == rd_addr) begin
                    rd_data = i_wData;
                end else begin
                    rd_data = mem_reg[rd_addr];
                    rd_busy = busy[rd_addr];
                end
            end
        end

        assign o_rData[gi*XLEN +: XLEN] = rd_data;
        assign o_rBusy[gi]              = rd_busy;
    end

endmodule
